// File: rtl/atto_pkg.sv
// rtl/atto_pkg.sv - shared select encodings and byte width for the arb21x8 slice
package atto_pkg;
   localparam int   BYTE_W = 8;
   localparam logic SEL_A  = 1'b0;
   localparam logic SEL_B  = 1'b1;
endpackage

// File: rtl/fifo_x8.sv
// rtl/fifo_x8.sv - synchronous byte FIFO with count, head-of-queue read
module fifo_x8
   import atto_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [BYTE_W-1:0]      din,
   output logic                   full,
   output logic                   empty,
   output logic [BYTE_W-1:0]      head,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage is not reset; only pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/m21x8.sv
// rtl/m21x8.sv - 2:1 byte datapath mux
module m21x8
   import atto_pkg::*;
(
   input  logic              sel,
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   output logic [BYTE_W-1:0] y
);
   assign y = (sel == SEL_B) ? b : a;
endmodule

// File: rtl/arb21x8.sv
// rtl/arb21x8.sv - two-channel buffered round-robin byte arbiter driving an m21x8 mux
module arb21x8
   import atto_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_valid,
   input  logic [BYTE_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [BYTE_W-1:0] b_data,
   output logic              b_ready,
   output logic              o_valid,
   output logic [BYTE_W-1:0] o_data,
   input  logic              o_ready,
   output logic              sel
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic              a_full, b_full;
   logic              a_empty, b_empty;
   logic [BYTE_W-1:0] a_head, b_head, mux_y;
   logic [CW-1:0]     a_count, b_count;
   logic              rr;
   logic              load;
   logic              grant;
   logic              gsel;
   logic              pop_a, pop_b;

   assign a_ready = (a_count != FULL_CNT);
   assign b_ready = (b_count != FULL_CNT);

   fifo_x8 #(.DEPTH(DEPTH)) u_fifo_a (
      .clk(clk), .reset_n(reset_n),
      .push(a_valid && !a_full), .pop(pop_a), .din(a_data),
      .full(a_full), .empty(a_empty), .head(a_head), .count(a_count)
   );

   fifo_x8 #(.DEPTH(DEPTH)) u_fifo_b (
      .clk(clk), .reset_n(reset_n),
      .push(b_valid && !b_full), .pop(pop_b), .din(b_data),
      .full(b_full), .empty(b_empty), .head(b_head), .count(b_count)
   );

   // When idle the mux keeps the last granted select so its output stays quiet.
   always_comb begin
      load  = !o_valid || o_ready;
      grant = 1'b0;
      gsel  = sel;
      if (load && (!a_empty || !b_empty)) begin
         grant = 1'b1;
         if (!a_empty && !b_empty) gsel = rr;
         else if (!b_empty)        gsel = SEL_B;
         else                      gsel = SEL_A;
      end
   end

   assign pop_a = grant && (gsel == SEL_A);
   assign pop_b = grant && (gsel == SEL_B);

   m21x8 u_mux (.sel(gsel), .a(a_head), .b(b_head), .y(mux_y));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         sel     <= SEL_A;
         rr      <= SEL_A;
      end else if (load) begin
         o_valid <= grant;
         if (grant) begin
            o_data <= mux_y;
            sel    <= gsel;
            rr     <= ~gsel;
         end
      end
   end
endmodule

// File: tb/tb_arb21x8.sv
// tb/tb_arb21x8.sv - scoreboard bench for arb21x8
module tb_arb21x8;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       a_valid = 1'b0, b_valid = 1'b0, o_ready = 1'b0;
   logic [7:0] a_data = 8'h00, b_data = 8'h00;
   logic       a_ready, b_ready, o_valid, sel;
   logic [7:0] o_data;

   int total = 0;
   int bad   = 0;
   logic [8:0] exp_q [$];

   arb21x8 #(.DEPTH(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready),
      .sel(sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Each negedge with valid&&ready is exactly one transfer at the next posedge.
   always @(negedge clk) begin
      if (reset_n && o_valid && o_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got %0h want none", {sel, o_data});
         end else begin
            chk("out_word", {23'b0, sel, o_data}, {23'b0, exp_q.pop_front()});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      a_valid = 1'b0;
      b_valid = 1'b0;
      o_ready = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic drain(input string name);
      o_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      chk(name, exp_q.size(), 0);
   endtask

   initial begin
      step();
      chk("rst_o_valid", o_valid, 0);
      chk("rst_o_data", o_data, 8'h00);
      chk("rst_sel", sel, 0);
      chk("rst_a_ready", a_ready, 1);
      chk("rst_b_ready", b_ready, 1);
      step();
      reset_n = 1'b1;

      // single word
      o_ready = 1'b1;
      a_valid = 1'b1; a_data = 8'h5A;
      exp_q.push_back({1'b0, 8'h5A});
      step();
      a_valid = 1'b0;
      chk("single_early", o_valid, 0);
      step();
      chk("single_valid", o_valid, 1);
      chk("single_data", o_data, 8'h5A);
      chk("single_sel", sel, 0);
      step();
      chk("single_empty", o_valid, 0);
      drain("single_drain");

      // fair interleave
      do_reset();
      o_ready = 1'b1;
      exp_q.push_back({1'b0, 8'h01});
      exp_q.push_back({1'b1, 8'h81});
      exp_q.push_back({1'b0, 8'h02});
      exp_q.push_back({1'b1, 8'h82});
      a_valid = 1'b1; a_data = 8'h01; b_valid = 1'b1; b_data = 8'h81;
      step();
      a_data = 8'h02; b_data = 8'h82;
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("il_valid", o_valid, 1);
         chk("il_sel", sel, i % 2);
         step();
      end
      chk("il_after", o_valid, 0);
      drain("il_drain");

      // backpressure
      do_reset();
      exp_q.push_back({1'b1, 8'h11});
      exp_q.push_back({1'b1, 8'h22});
      exp_q.push_back({1'b1, 8'h33});
      b_valid = 1'b1; b_data = 8'h11;
      step();
      b_data = 8'h22;
      step();
      chk("bp_ready_mid", b_ready, 1);
      b_data = 8'h33;
      step();
      b_valid = 1'b0;
      chk("bp_b_full", b_ready, 0);
      chk("bp_o_valid", o_valid, 1);
      chk("bp_o_data", o_data, 8'h11);
      chk("bp_count", dut.u_fifo_b.count, 2);
      o_ready = 1'b1;
      step();
      chk("bp_ready_back", b_ready, 1);
      chk("bp_second", o_data, 8'h22);
      drain("bp_drain");

      // stall hold with both FIFOs non-empty
      do_reset();
      exp_q.push_back({1'b0, 8'hA1});
      exp_q.push_back({1'b1, 8'hB1});
      exp_q.push_back({1'b0, 8'hA2});
      exp_q.push_back({1'b1, 8'hB2});
      exp_q.push_back({1'b0, 8'hA3});
      a_valid = 1'b1; a_data = 8'hA1; b_valid = 1'b1; b_data = 8'hB1;
      step();
      a_data = 8'hA2; b_valid = 1'b0;
      step();
      a_data = 8'hA3; b_valid = 1'b1; b_data = 8'hB2;
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("st_data", o_data, 8'hA1);
         chk("st_sel", sel, 0);
         chk("st_cnt_a", dut.u_fifo_a.count, 2);
         chk("st_cnt_b", dut.u_fifo_b.count, 2);
         step();
      end
      drain("st_drain");

      // reset mid-stream
      do_reset();
      b_valid = 1'b1; b_data = 8'h77;
      step();
      b_data = 8'h78; a_valid = 1'b1; a_data = 8'h66;
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      chk("mr_pre_sel", sel, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("mr_o_valid", o_valid, 0);
      chk("mr_o_data", o_data, 8'h00);
      chk("mr_sel", sel, 0);
      chk("mr_a_ready", a_ready, 1);
      step();
      reset_n = 1'b1;
      o_ready = 1'b1;
      a_valid = 1'b1; a_data = 8'h33;
      exp_q.push_back({1'b0, 8'h33});
      step();
      a_valid = 1'b0;
      step();
      chk("mr_new_valid", o_valid, 1);
      chk("mr_new_data", o_data, 8'h33);
      step();
      chk("mr_no_stale0", o_valid, 0);
      step();
      chk("mr_no_stale1", o_valid, 0);
      drain("mr_drain");

      // simultaneous push/pop at count 1
      do_reset();
      o_ready = 1'b1;
      a_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         a_data = 8'(8'hC0 + i);
         exp_q.push_back({1'b0, 8'(8'hC0 + i)});
         step();
         chk("pp_count", dut.u_fifo_a.count, 1);
         if (i > 0) chk("pp_valid", o_valid, 1);
      end
      a_valid = 1'b0;
      drain("pp_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/arb21x8.md
# arb21x8

Two-channel, 8-bit buffered round-robin arbiter that generates the select for, and drives, an m21x8 datapath mux. Each input channel has a small FIFO. A fair arbiter picks one non-empty FIFO per cycle, steers its head word through the 2:1 byte mux, and registers the result into a single valid/ready output stage. The block sits directly upstream of any consumer that takes one byte stream merged from two producers.

## Interface
- `DEPTH`, default 2: entries per input FIFO; power of two, minimum 2.
- `clk` — in — 1 — sole clock; all state updates on the rising edge.
- `reset_n` — in — 1 — asynchronous, active-low reset.
- `a_valid` — in — 1 — channel A word present.
- `a_data` — in — 8 — channel A word.
- `a_ready` — out — 1 — FIFO A not full.
- `b_valid` — in — 1 — channel B word present.
- `b_data` — in — 8 — channel B word.
- `b_ready` — out — 1 — FIFO B not full.
- `o_valid` — out — 1 — output register holds a word.
- `o_data` — out — 8 — output word.
- `o_ready` — in — 1 — consumer accepts the output word.
- `sel` — out — 1 — current mux select: 0 = channel A, 1 = channel B.

## Operation
- **Input push:** an input word is pushed when `x_valid && x_ready` at a clock edge.
- **Input ready:** `x_ready = (count_x != DEPTH)`. It is combinational from the count, with no bypass when full.
- **Load condition:** `load = !o_valid || o_ready`, meaning the output register is free or draining this cycle.
- **Arbitration** happens when load is true and at least one FIFO is non-empty. It is combinational from the FIFO empty flags and the round-robin pointer `rr`.
  - Only A non-empty: grant A.
  - Only B non-empty: grant B.
  - Both non-empty: grant the side `rr` points at.
- **After a grant:**
  - `sel` takes the granted side's value.
  - The mux output `head_a`/`head_b` loads into `o_data`.
  - `o_valid` is set to 1.
  - The granted FIFO pops.
  - `rr` becomes the non-granted side.
- **No grant while load is true:** `o_valid` is set to 0 when `o_ready` drained the word. Otherwise `o_valid` stays 0.
- **Stall:** `o_valid && !o_ready` holds `o_data`, `o_valid`, `sel` and `rr` unchanged, and neither FIFO pops.
- **Idle select:** `sel` holds its last granted value. It is registered and glitch-free.
- **Simultaneous push and pop** on the same FIFO in one cycle is legal at any count below DEPTH; the count is unchanged.
- **FIFO pointers** are `log2(DEPTH)` bits and wrap naturally. The count is `log2(DEPTH)+1` bits.
- **Word order:** order within a channel is preserved. Channels interleave strictly A,B,A,B while both remain non-empty.

## Timing
- **Reset values:**
  - `o_valid`=0, `o_data`=8'h00, `sel`=0, `rr`=0 (A first).
  - Both FIFOs empty, so `a_ready`=`b_ready`=1 while `reset_n` is low.
- **Reset assertion** at any time, including mid-stall, clears all state immediately and discards buffered words.
- **Latency:** a word pushed at edge E0 is visible on `o_data`/`o_valid` after edge E1 when uncontested. Minimum latency is 2 cycles from input presentation to output valid.
- **Throughput:** one word per cycle while `o_ready`=1 and any FIFO is non-empty.
- **Readiness:** `x_ready` can fall only on the edge that fills the FIFO. It rises the cycle after a pop from full.

## Structure
- **Shared package `atto_pkg`:** constants `SEL_A`=1'b0 and `SEL_B`=1'b1, and the byte width constant 8.
- **Sub-module `fifo_x8`:** synchronous FIFO with push/pop/full/empty/head and count, parameterised by DEPTH. It is instantiated twice.
- **Datapath:** one `m21x8` instance, driven by the combinational grant select during load.
- **Control:** lives in `arb21x8`, consisting of the grant logic, the `rr` register and the output register.

## Test plan
- **Single word:** after reset, push A=8'h5A with `o_ready`=1 → `o_valid`=1, `o_data`=8'h5A, `sel`=0 two cycles after presentation; output empty next cycle.
- **Fair interleave:** preload A={01,02} and B={81,82}, then hold `o_ready`=1 → output 01,81,02,82 on consecutive cycles, `sel` toggling 0,1,0,1.
- **Backpressure:** `o_ready`=0, push 3 words into B → first word sits in the output register, 2 fill FIFO B, `b_ready`=0. Release `o_ready` → the 3 words emerge in order and `b_ready` returns to 1 one cycle after the first pop.
- **Stall hold:** `o_valid`=1, `o_ready`=0 for 5 cycles while A and B are both non-empty → `o_data`, `sel` and `rr` are unchanged and both FIFO counts are stable.
- **Reset mid-stream:** assert `reset_n`=0 asynchronously with both FIFOs holding data → `o_valid`=0, `o_data`=00 and `sel`=0 immediately. After release, the next push A=8'h33 emerges alone with no stale words.
- **Simultaneous push/pop:** count=1 on A with continuous push and `o_ready`=1 → one word per cycle, and the count stays 1 throughout.
